// File: rtl/cmd_mem_writer_mc.sv
// Multi-channel pulse-command memory writer: stages one command record per WR and writes it into
// the selected channel's circular region of an external RAM, with an "empty" sentinel sweep on reset/CLR_ALL.
module cmd_mem_writer_mc #(
    parameter  int N_CH   = 2,
    parameter  int ADDR_W = 7,
    parameter  int FREQ_W = 48,
    parameter  int TIME_W = 64,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int REC_W  = TIME_W + 2*FREQ_W + 178,
    localparam int AW     = CH_W + ADDR_W
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic [FREQ_W-1:0]          FREQ,
    input  logic [FREQ_W-1:0]          FREQ_STEP,
    input  logic [31:0]                FREQ_RATE,
    input  logic [TIME_W-1:0]          TIME_START,
    input  logic [15:0]                N_impulse,
    input  logic [1:0]                 TYPE_impulse,
    input  logic [31:0]                Interval_Ti,
    input  logic [31:0]                Interval_Tp,
    input  logic [31:0]                Tblank1,
    input  logic [31:0]                Tblank2,
    input  logic [CH_W-1:0]            CH_SEL,
    input  logic                       WR,
    input  logic                       CLR_ALL,
    input  logic [N_CH-1:0]            RELEASE,
    output logic                       busy,
    output logic                       wr_ack,
    output logic                       wr_err,
    output logic [N_CH-1:0]            full,
    output logic [N_CH*(ADDR_W+1)-1:0] count,
    output logic                       mem_wren,
    output logic [AW-1:0]              mem_addr,
    output logic [REC_W-1:0]           mem_data
);

    localparam logic [AW-1:0]     LAST_CLR = AW'(N_CH * (2**ADDR_W) - 1);
    localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [REC_W-1:0]  SENTINEL = {{TIME_W{1'b1}}, {(REC_W-TIME_W){1'b0}}};

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WRITE} state_t;

    state_t              r_state, w_state_nxt;
    logic [AW-1:0]       r_clr_addr;
    logic [ADDR_W-1:0]   r_wr_ptr [N_CH];
    logic [ADDR_W-1:0]   r_rd_ptr [N_CH];
    logic [ADDR_W:0]     r_count  [N_CH];
    logic [ADDR_W:0]     w_cnt_nxt[N_CH];
    logic [N_CH-1:0]     r_full;
    logic [N_CH-1:0]     w_inc, w_dec;
    logic [REC_W-1:0]    r_stage, w_rec;
    logic [CH_W-1:0]     r_stage_ch;
    logic                r_mem_wren, r_wr_ack, r_wr_err;
    logic [AW-1:0]       r_mem_addr;
    logic [REC_W-1:0]    r_mem_data;
    logic                w_ch_valid, w_ch_full, w_accept, w_reject, w_clr_start, w_clr_done;

    assign w_rec = {TIME_START, FREQ, FREQ_STEP, FREQ_RATE, N_impulse, TYPE_impulse,
                    Interval_Ti, Interval_Tp, Tblank1, Tblank2};

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) r_state <= S_CLEAR;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_clr_start = 1'b0;
        w_clr_done  = (r_clr_addr == LAST_CLR);
        w_ch_valid  = (int'(CH_SEL) < N_CH);
        w_ch_full   = w_ch_valid ? r_full[CH_SEL] : 1'b1;
        case (r_state)
            S_CLEAR: begin
                w_reject = WR;
                if (w_clr_done) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (CLR_ALL) begin
                    w_clr_start = 1'b1;
                    w_reject    = WR;
                    w_state_nxt = S_CLEAR;
                end else if (WR) begin
                    if (w_ch_valid && !w_ch_full) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                w_reject    = WR;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // A completing write and a RELEASE on the same channel cancel in the count.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_inc[c]     = (r_state == S_WRITE) && (r_stage_ch == CH_W'(c));
            w_dec[c]     = RELEASE[c] && (r_state != S_CLEAR) && (r_count[c] != '0);
            w_cnt_nxt[c] = r_count[c] + (ADDR_W+1)'(w_inc[c]) - (ADDR_W+1)'(w_dec[c]);
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_clr_addr <= '0;
            r_mem_wren <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_wr_ack   <= 1'b0;
            r_wr_err   <= 1'b0;
            r_stage    <= '0;
            r_stage_ch <= '0;
            r_full     <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_count[c]  <= '0;
            end
        end else begin
            r_mem_wren <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_wr_err   <= w_reject;
            if (w_accept) begin
                r_stage    <= w_rec;
                r_stage_ch <= CH_SEL;
            end
            case (r_state)
                S_CLEAR: begin
                    r_mem_wren <= 1'b1;
                    r_mem_addr <= r_clr_addr;
                    r_mem_data <= SENTINEL;
                    r_clr_addr <= w_clr_done ? '0 : r_clr_addr + 1'b1;
                end
                S_WRITE: begin
                    r_mem_wren <= 1'b1;
                    r_wr_ack   <= 1'b1;
                    r_mem_addr <= {r_stage_ch, r_wr_ptr[r_stage_ch]};
                    r_mem_data <= r_stage;
                end
                default: ;
            endcase
            if (w_clr_start) begin
                r_clr_addr <= '0;
                r_full     <= '0;
                for (int c = 0; c < N_CH; c++) begin
                    r_wr_ptr[c] <= '0;
                    r_rd_ptr[c] <= '0;
                    r_count[c]  <= '0;
                end
            end else begin
                for (int c = 0; c < N_CH; c++) begin
                    if (w_inc[c]) r_wr_ptr[c] <= r_wr_ptr[c] + 1'b1;
                    if (w_dec[c]) r_rd_ptr[c] <= r_rd_ptr[c] + 1'b1;
                    r_count[c] <= w_cnt_nxt[c];
                    r_full[c]  <= (w_cnt_nxt[c] == DEPTH);
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int c = 0; c < N_CH; c++) count[c*(ADDR_W+1) +: ADDR_W+1] = r_count[c];
    end

    assign busy     = (r_state != S_IDLE);
    assign full     = r_full;
    assign wr_ack   = r_wr_ack;
    assign wr_err   = r_wr_err;
    assign mem_wren = r_mem_wren;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;

endmodule
